// File: rtl/branch_resolver.sv
// Resolves one RISC-V conditional branch at a time from captured ALU flags,
// raising a redirect to fetch for taken branches and keeping outcome counters.
module branch_resolver #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          flags,
  input  logic                a_msb,
  input  logic                b_msb,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] imm,
  output logic                redir_valid,
  input  logic                redir_ready,
  output logic [WORDSIZE-1:0] redir_pc,
  output logic                done,
  output logic                taken,
  output logic                fault,
  output logic [15:0]         br_count,
  output logic [15:0]         tk_count
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT
  } state_t;

  state_t state, state_next;

  logic [3:0]          flags_q;
  logic                a_msb_q;
  logic                b_msb_q;
  logic [2:0]          funct3_q;
  logic [WORDSIZE-1:0] pc_q;
  logic [WORDSIZE-1:0] imm_q;

  logic                accept;
  logic                eq, lt_s, lt_u, cond, illegal;
  logic [WORDSIZE-1:0] target;
  logic                done_next, taken_next, fault_next;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Unsigned less-than falls back to the signed result when the operand MSBs agree.
  assign eq     = flags_q[0];
  assign lt_s   = flags_q[1] ^ flags_q[2];
  assign lt_u   = (a_msb_q != b_msb_q) ? b_msb_q : lt_s;
  assign target = pc_q + imm_q;

  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign illegal = (funct3_q == 3'b010) || (funct3_q == 3'b011) || !flags_q[3] ||
                   (cond && (target[1:0] != 2'b00));

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    taken_next = 1'b0;
    fault_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = EVAL;
      end
      EVAL: begin
        if (illegal) begin
          state_next = IDLE;
          done_next  = 1'b1;
          fault_next = 1'b1;
        end else if (!cond) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
          taken_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      flags_q     <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      funct3_q    <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      done        <= 1'b0;
      taken       <= 1'b0;
      fault       <= 1'b0;
      br_count    <= '0;
      tk_count    <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      taken <= taken_next;
      fault <= fault_next;
      if (accept) begin
        flags_q  <= flags;
        a_msb_q  <= a_msb;
        b_msb_q  <= b_msb;
        funct3_q <= funct3;
        pc_q     <= pc;
        imm_q    <= imm;
      end
      if (state == EVAL && state_next == REDIRECT) begin
        redir_valid <= 1'b1;
        redir_pc    <= target;
      end else if (state == REDIRECT && redir_ready) begin
        redir_valid <= 1'b0;
      end
      // Counters advance together with the done pulse and stick at all-ones.
      if (done_next && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (taken_next && tk_count != 16'hFFFF) tk_count <= tk_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed-vector bench for branch_resolver: one task per scenario, with
// expected values worked out by hand for each request.
module tb_branch_resolver;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   flags;
  logic         a_msb, b_msb;
  logic [2:0]   funct3;
  logic [W-1:0] pc, imm;
  logic         redir_valid;
  logic         redir_ready;
  logic [W-1:0] redir_pc;
  logic         done, taken, fault;
  logic [15:0]  br_count, tk_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolver #(.WORDSIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flags(flags), .a_msb(a_msb), .b_msb(b_msb), .funct3(funct3),
    .pc(pc), .imm(imm), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .done(done), .taken(taken), .fault(fault),
    .br_count(br_count), .tk_count(tk_count)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [3:0] fl, input logic am,
                       input logic bm, input logic [W-1:0] p, input logic [W-1:0] i);
    in_valid = 1'b1;
    funct3 = f3; flags = fl; a_msb = am; b_msb = bm; pc = p; imm = i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_redir_valid: got %b want 0", redir_valid); end
    n_cmp++; if (redir_pc !== 64'h0) begin n_err++; $display("[TB] FAIL reset_redir_pc: got %h want 0", redir_pc); end
    n_cmp++; if ({done, taken, fault} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_pulses: got %b want 000", {done, taken, fault}); end
    n_cmp++; if ({br_count, tk_count} !== 32'h0) begin n_err++; $display("[TB] FAIL reset_counts: got %h/%h want 0/0", br_count, tk_count); end
  endtask

  task automatic test_beq_taken();
    redir_ready = 1'b1;
    drive(3'b000, 4'b1001, 1'b0, 1'b0, 64'h100, 64'h20);
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({done, redir_valid, in_ready} !== 3'b000) begin n_err++; $display("[TB] FAIL beq_eval: got done/rv/rdy %b want 000", {done, redir_valid, in_ready}); end
    tick();
    n_cmp++; if (redir_valid !== 1'b1) begin n_err++; $display("[TB] FAIL beq_redir_valid: got %b want 1", redir_valid); end
    n_cmp++; if (redir_pc !== 64'h120) begin n_err++; $display("[TB] FAIL beq_redir_pc: got %h want 120", redir_pc); end
    tick();
    n_cmp++; if ({done, taken, fault, redir_valid} !== 4'b1100) begin n_err++; $display("[TB] FAIL beq_done: got d/t/f/rv %b want 1100", {done, taken, fault, redir_valid}); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL beq_done_pulse: got %b want 0", done); end
    n_cmp++; if ({br_count, tk_count} !== {16'd1, 16'd1}) begin n_err++; $display("[TB] FAIL beq_counts: got %0d/%0d want 1/1", br_count, tk_count); end
  endtask

  task automatic test_blt_not_taken();
    drive(3'b100, 4'b1110, 1'b1, 1'b1, 64'h100, 64'h40);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL blt_early_done: got %b want 0", done); end
    tick();
    n_cmp++; if ({done, taken, fault, redir_valid} !== 4'b1000) begin n_err++; $display("[TB] FAIL blt_done: got d/t/f/rv %b want 1000", {done, taken, fault, redir_valid}); end
    n_cmp++; if ({br_count, tk_count} !== {16'd2, 16'd1}) begin n_err++; $display("[TB] FAIL blt_counts: got %0d/%0d want 2/1", br_count, tk_count); end
    tick();
  endtask

  task automatic test_bltu();
    drive(3'b110, 4'b1010, 1'b1, 1'b0, 64'h200, 64'h40);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({done, taken, redir_valid} !== 3'b100) begin n_err++; $display("[TB] FAIL bltu_nt: got d/t/rv %b want 100", {done, taken, redir_valid}); end
    tick();
    drive(3'b110, 4'b1010, 1'b0, 1'b1, 64'h200, 64'h40);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({redir_valid, redir_pc} !== {1'b1, 64'h240}) begin n_err++; $display("[TB] FAIL bltu_redir: got %b/%h want 1/240", redir_valid, redir_pc); end
    tick();
    n_cmp++; if ({done, taken} !== 2'b11) begin n_err++; $display("[TB] FAIL bltu_taken: got d/t %b want 11", {done, taken}); end
    n_cmp++; if ({br_count, tk_count} !== {16'd4, 16'd2}) begin n_err++; $display("[TB] FAIL bltu_counts: got %0d/%0d want 4/2", br_count, tk_count); end
    tick();
  endtask

  task automatic test_fault();
    logic [2:0]   f3_tab  [3] = '{3'b010, 3'b000, 3'b000};
    logic [3:0]   fl_tab  [3] = '{4'b1001, 4'b0001, 4'b1001};
    logic [W-1:0] imm_tab [3] = '{64'h20, 64'h20, 64'h22};
    for (int k = 0; k < 3; k++) begin
      drive(f3_tab[k], fl_tab[k], 1'b0, 1'b0, 64'h100, imm_tab[k]);
      tick();
      in_valid = 1'b0;
      tick();
      n_cmp++; if ({done, fault, taken, redir_valid} !== 4'b1100) begin n_err++; $display("[TB] FAIL fault_%0d: got d/f/t/rv %b want 1100", k, {done, fault, taken, redir_valid}); end
      n_cmp++; if ({br_count, tk_count} !== {16'(5 + k), 16'd2}) begin n_err++; $display("[TB] FAIL fault_counts_%0d: got %0d/%0d want %0d/2", k, br_count, tk_count, 5 + k); end
      tick();
    end
  endtask

  task automatic test_redirect_stall();
    redir_ready = 1'b0;
    drive(3'b001, 4'b1000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    tick();
    in_valid = 1'b0;
    tick();
    drive(3'b000, 4'b1001, 1'b0, 1'b0, 64'h500, 64'h8);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({redir_valid, redir_pc} !== {1'b1, 64'h10}) begin n_err++; $display("[TB] FAIL stall_hold_%0d: got %b/%h want 1/10", i, redir_valid, redir_pc); end
      n_cmp++; if ({in_ready, done} !== 2'b00) begin n_err++; $display("[TB] FAIL stall_busy_%0d: got rdy/d %b want 00", i, {in_ready, done}); end
      tick();
    end
    in_valid = 1'b0;
    redir_ready = 1'b1;
    n_cmp++; if ({redir_valid, redir_pc} !== {1'b1, 64'h10}) begin n_err++; $display("[TB] FAIL stall_final: got %b/%h want 1/10", redir_valid, redir_pc); end
    tick();
    n_cmp++; if ({done, taken, redir_valid} !== 3'b110) begin n_err++; $display("[TB] FAIL stall_done: got d/t/rv %b want 110", {done, taken, redir_valid}); end
    n_cmp++; if ({br_count, tk_count} !== {16'd8, 16'd3}) begin n_err++; $display("[TB] FAIL stall_counts: got %0d/%0d want 8/3", br_count, tk_count); end
    tick();
    n_cmp++; if ({in_ready, done} !== 2'b10) begin n_err++; $display("[TB] FAIL stall_no_ghost: got rdy/d %b want 10", {in_ready, done}); end
  endtask

  task automatic test_back_to_back();
    drive(3'b000, 4'b1000, 1'b0, 1'b0, 64'h100, 64'h4);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({done, in_ready} !== 2'b11) begin n_err++; $display("[TB] FAIL b2b_first: got d/rdy %b want 11", {done, in_ready}); end
    drive(3'b000, 4'b1000, 1'b0, 1'b0, 64'h104, 64'h4);
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({done, in_ready} !== 2'b00) begin n_err++; $display("[TB] FAIL b2b_accepted: got d/rdy %b want 00", {done, in_ready}); end
    tick();
    n_cmp++; if ({done, taken} !== 2'b10) begin n_err++; $display("[TB] FAIL b2b_second: got d/t %b want 10", {done, taken}); end
    n_cmp++; if ({br_count, tk_count} !== {16'd10, 16'd3}) begin n_err++; $display("[TB] FAIL b2b_counts: got %0d/%0d want 10/3", br_count, tk_count); end
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    redir_ready = 1'b0;
    drive(3'b000, 4'b1001, 1'b0, 1'b0, 64'h300, 64'h4);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({redir_valid, redir_pc} !== {1'b1, 64'h304}) begin n_err++; $display("[TB] FAIL rst_pre: got %b/%h want 1/304", redir_valid, redir_pc); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if ({redir_valid, in_ready} !== 2'b01) begin n_err++; $display("[TB] FAIL rst_redir: got rv/rdy %b want 01", {redir_valid, in_ready}); end
    n_cmp++; if ({br_count, tk_count} !== 32'h0) begin n_err++; $display("[TB] FAIL rst_counts: got %0d/%0d want 0/0", br_count, tk_count); end
    redir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({done, redir_valid} !== 2'b00) begin n_err++; $display("[TB] FAIL rst_no_done_%0d: got d/rv %b want 00", i, {done, redir_valid}); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; redir_ready = 1'b0;
    flags = '0; a_msb = 1'b0; b_msb = 1'b0; funct3 = '0; pc = '0; imm = '0;
    #1;
    test_reset();
    test_beq_taken();
    test_blt_not_taken();
    test_bltu();
    test_fault();
    test_redirect_stall();
    test_back_to_back();
    test_reset_mid_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, giving the width of the PC, immediate and target.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: branch request present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port flags, input, 4 bits: ALU flags of a-b, {extra, overflow, msb, zero}, so flags[0]=zero, flags[1]=msb, flags[2]=overflow, flags[3]=extra.
REQ-007 SHALL have ports a_msb and b_msb, input, 1 bit each: bit WORDSIZE-1 of the compared operands.
REQ-008 SHALL have port funct3, input, 3 bits: RV branch condition.
REQ-009 SHALL have ports pc and imm, input, WORDSIZE bits each: branch PC and sign-extended offset.
REQ-010 SHALL have port redir_valid, output, 1 bit: redirect request to fetch.
REQ-011 SHALL have port redir_ready, input, 1 bit: fetch accepts the redirect.
REQ-012 SHALL have port redir_pc, output, WORDSIZE bits: redirect target.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a request retires.
REQ-014 SHALL have port taken, output, 1 bit: outcome of the last request, valid while done=1.
REQ-015 SHALL have port fault, output, 1 bit: one-cycle pulse with done when the request is illegal.
REQ-016 SHALL have ports br_count and tk_count, output, 16 bits each: retired-branch and taken-branch counters.

Function
REQ-017 SHALL implement states IDLE, EVAL and REDIRECT; in_ready=1 only in IDLE.
REQ-018 SHALL capture flags, a_msb, b_msb, funct3, pc and imm into internal registers on in_valid&&in_ready, then move to EVAL.
REQ-019 SHALL compute in EVAL: eq=zero; lt_s=msb^overflow; lt_u=(a_msb!=b_msb)?b_msb:lt_s.
REQ-020 SHALL map funct3 to a condition: 000 eq, 001 !eq, 100 lt_s, 101 !lt_s, 110 lt_u, 111 !lt_u.
REQ-021 SHALL compute target=pc+imm modulo 2^WORDSIZE.
REQ-022 SHALL raise fault when funct3 is 010 or 011, when captured flags[3]=0, or when the condition holds and target[1:0]!=00.
REQ-023 SHALL, on a fault, report taken=0, skip the redirect, and go EVAL->IDLE with done=fault=1 for one cycle.
REQ-024 SHALL, when the condition is false, go EVAL->IDLE with done=1 and taken=0 for one cycle.
REQ-025 SHALL, when the condition is true and there is no fault, go EVAL->REDIRECT; redir_valid=1 and redir_pc=target, both registered, starting on the cycle after EVAL.
REQ-026 SHALL hold redir_valid and redir_pc stable until redir_ready=1; on the handshake cycle go REDIRECT->IDLE, with done=1 and taken=1 on the next cycle.
REQ-027 SHALL make the latency accept->done 2 cycles for not-taken and fault, and 3+(wait cycles) for taken.
REQ-028 SHALL ignore in_valid outside IDLE; the request is not consumed.
REQ-029 SHALL increment br_count on every done and tk_count on every done with taken=1, each saturating at 0xFFFF.
REQ-030 SHALL, when a done pulse and a new accept fall in the same cycle, do both (back-to-back requests).

Reset
REQ-031 SHALL, on rst_n=0 at a clock edge, reset to state IDLE with redir_valid=0, redir_pc=0, done=0, taken=0, fault=0, br_count=0, tk_count=0; in_ready=1 on the following cycle.
REQ-032 SHALL, on reset mid-operation (EVAL or REDIRECT), abandon the request silently: no done and no count change.

Verification
REQ-033 SHALL cover BEQ, flags=4'b1001, pc=0x100, imm=0x20, redir_ready=1: redir_valid with redir_pc=0x120, then done=1 and taken=1, and br_count=1, tk_count=1.
REQ-034 SHALL cover BLT, flags=4'b1110 (msb=1, ovf=1): lt_s=0, so done=1, taken=0, no redir_valid, and done arrives 2 cycles after the accept.
REQ-035 SHALL cover BLTU, a_msb=1, b_msb=0, flags=4'b1010: lt_u=0, so taken=0; repeated with a_msb=0, b_msb=1: taken=1.
REQ-036 SHALL cover funct3=3'b010, and separately flags[3]=0: done=fault=1, taken=0, tk_count unchanged.
REQ-037 SHALL cover a taken branch with redir_ready held 0 for 5 cycles: redir_valid and redir_pc stable throughout, and in_valid=1 during the wait is not accepted.
REQ-038 SHALL cover rst_n=0 while in REDIRECT: redir_valid=0 on the next cycle, counters are 0, and no done pulse occurs.
